// File: rtl/bcd_display_formatter.sv
// Range-checks a 40-bit magnitude and converts it with an iterative double-dabble engine.
// Drives six display codes with leading-zero blanking, minus placement and an "Err" message.
module bcd_display_formatter #(
  parameter logic [5:0] BLANK_CODE = 6'd63,
  parameter logic [5:0] MINUS_CODE = 6'd62,
  parameter logic [5:0] E_CODE     = 6'd14,
  parameter logic [5:0] R_CODE     = 6'd27
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_start,
  input  logic [39:0] i_value,
  input  logic        i_sign,
  input  logic        i_err,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_err,
  output logic [5:0]  o_digit_pos,
  output logic [5:0]  o_ten_pos,
  output logic [5:0]  o_hundred_pos,
  output logic [5:0]  o_thousand_pos,
  output logic [5:0]  o_ten_thousand_pos,
  output logic [5:0]  o_hundred_thousand_pos
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CHECK  = 2'd1,
    SHIFT  = 2'd2,
    FORMAT = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [39:0] value_q, value_d;
  logic        sign_q, sign_d;
  logic        err_in_q, err_in_d;
  logic        err_flag_q, err_flag_d;
  logic [19:0] shift_q, shift_d;
  logic [23:0] bcd_q, bcd_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        oerr_q, oerr_d;
  logic [5:0]  disp_q [6];
  logic [5:0]  disp_d [6];

  logic [23:0] bcd_adj;
  logic [5:0]  fmt [6];
  logic [3:0]  nib;
  int unsigned msd;

  // Add-3 correction applied to every nibble before the shift.
  always_comb begin
    bcd_adj = bcd_q;
    for (int unsigned i = 0; i < 6; i++) begin
      nib = bcd_q[4*i +: 4];
      if (nib >= 4'd5) bcd_adj[4*i +: 4] = nib + 4'd3;
    end
  end

  // Blanking and minus placement relative to the most-significant nonzero digit.
  always_comb begin
    msd = 0;
    for (int unsigned i = 0; i < 6; i++) begin
      if (bcd_q[4*i +: 4] != 4'd0) msd = i;
    end
    for (int unsigned i = 0; i < 6; i++) begin
      if (i <= msd)
        fmt[i] = {2'b00, bcd_q[4*i +: 4]};
      else if ((i == msd + 1) && sign_q && (bcd_q != '0))
        fmt[i] = MINUS_CODE;
      else
        fmt[i] = BLANK_CODE;
    end
  end

  always_comb begin
    state_d    = state_q;
    value_d    = value_q;
    sign_d     = sign_q;
    err_in_d   = err_in_q;
    err_flag_d = err_flag_q;
    shift_d    = shift_q;
    bcd_d      = bcd_q;
    cnt_d      = cnt_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    oerr_d     = oerr_q;
    disp_d     = disp_q;

    case (state_q)
      IDLE: begin
        if (i_start) begin
          value_d  = i_value;
          sign_d   = i_sign;
          err_in_d = i_err;
          busy_d   = 1'b1;
          state_d  = CHECK;
        end
      end
      CHECK: begin
        if (err_in_q || (value_q > 40'd999999) || (sign_q && (value_q > 40'd99999))) begin
          err_flag_d = 1'b1;
          state_d    = FORMAT;
        end else begin
          err_flag_d = 1'b0;
          shift_d    = value_q[19:0];
          bcd_d      = '0;
          cnt_d      = '0;
          state_d    = SHIFT;
        end
      end
      SHIFT: begin
        {bcd_d, shift_d} = {bcd_adj[22:0], shift_q, 1'b0};
        cnt_d            = cnt_q + 5'd1;
        if (cnt_q == 5'd19) state_d = FORMAT;
      end
      FORMAT: begin
        if (err_flag_q) begin
          disp_d[5] = BLANK_CODE;
          disp_d[4] = BLANK_CODE;
          disp_d[3] = BLANK_CODE;
          disp_d[2] = E_CODE;
          disp_d[1] = R_CODE;
          disp_d[0] = R_CODE;
        end else begin
          disp_d = fmt;
        end
        oerr_d  = err_flag_q;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q    <= IDLE;
      value_q    <= '0;
      sign_q     <= 1'b0;
      err_in_q   <= 1'b0;
      err_flag_q <= 1'b0;
      shift_q    <= '0;
      bcd_q      <= '0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      oerr_q     <= 1'b0;
      for (int unsigned i = 0; i < 6; i++) disp_q[i] <= BLANK_CODE;
    end else begin
      state_q    <= state_d;
      value_q    <= value_d;
      sign_q     <= sign_d;
      err_in_q   <= err_in_d;
      err_flag_q <= err_flag_d;
      shift_q    <= shift_d;
      bcd_q      <= bcd_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      oerr_q     <= oerr_d;
      disp_q     <= disp_d;
    end
  end

  assign o_busy                 = busy_q;
  assign o_done                 = done_q;
  assign o_err                  = oerr_q;
  assign o_digit_pos            = disp_q[0];
  assign o_ten_pos              = disp_q[1];
  assign o_hundred_pos          = disp_q[2];
  assign o_thousand_pos         = disp_q[3];
  assign o_ten_thousand_pos     = disp_q[4];
  assign o_hundred_thousand_pos = disp_q[5];

endmodule

// File: tb/tb_bcd_display_formatter.sv
// Randomized and directed checks of bcd_display_formatter against an arithmetic display model.
module tb_bcd_display_formatter;

  localparam logic [5:0] BLANK = 6'd63;
  localparam logic [5:0] MINUS = 6'd62;
  localparam logic [5:0] ECODE = 6'd14;
  localparam logic [5:0] RCODE = 6'd27;

  logic        clk;
  logic        rst;
  logic        i_start;
  logic [39:0] i_value;
  logic        i_sign;
  logic        i_err;
  logic        o_busy;
  logic        o_done;
  logic        o_err;
  logic [5:0]  d0, d1, d2, d3, d4, d5;

  int n_total;
  int n_bad;

  bcd_display_formatter #(
    .BLANK_CODE(BLANK),
    .MINUS_CODE(MINUS),
    .E_CODE(ECODE),
    .R_CODE(RCODE)
  ) dut (
    .i_clk(clk),
    .i_reset(rst),
    .i_start(i_start),
    .i_value(i_value),
    .i_sign(i_sign),
    .i_err(i_err),
    .o_busy(o_busy),
    .o_done(o_done),
    .o_err(o_err),
    .o_digit_pos(d0),
    .o_ten_pos(d1),
    .o_hundred_pos(d2),
    .o_thousand_pos(d3),
    .o_ten_thousand_pos(d4),
    .o_hundred_thousand_pos(d5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] disp_now();
    return 64'({d5, d4, d3, d2, d1, d0});
  endfunction

  function automatic bit model_err(input logic [39:0] v, input logic s, input logic e);
    longint unsigned val;
    val = 64'(v);
    return e || (val > 999999) || (s && (val > 99999));
  endfunction

  // Display = decimal digits of the value, minus just left of them, blanks elsewhere.
  function automatic logic [63:0] model_disp(input logic [39:0] v, input logic s, input logic e);
    longint unsigned val;
    longint unsigned t;
    longint unsigned pw;
    int ndig;
    logic [5:0] p [6];
    val = 64'(v);
    if (model_err(v, s, e)) return 64'({BLANK, BLANK, BLANK, ECODE, RCODE, RCODE});
    ndig = 1;
    t = val;
    while (t >= 10) begin
      t = t / 10;
      ndig++;
    end
    pw = 1;
    for (int i = 0; i < 6; i++) begin
      if (i < ndig)                       p[i] = 6'((val / pw) % 10);
      else if (i == ndig && s && val != 0) p[i] = MINUS;
      else                                 p[i] = BLANK;
      pw = pw * 10;
    end
    return 64'({p[5], p[4], p[3], p[2], p[1], p[0]});
  endfunction

  task automatic run_conv(input logic [39:0] v, input logic s, input logic e, input string tag);
    int cyc;
    bit exp_err;
    exp_err = model_err(v, s, e);
    @(negedge clk);
    i_value = v;
    i_sign  = s;
    i_err   = e;
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    check_eq({tag, "_busy"}, 64'(o_busy), 64'd1);
    cyc = 0;
    while (!o_done && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check_eq({tag, "_lat"}, 64'(cyc), exp_err ? 64'd2 : 64'd22);
    check_eq({tag, "_disp"}, disp_now(), model_disp(v, s, e));
    check_eq({tag, "_err"}, 64'(o_err), 64'(exp_err));
    check_eq({tag, "_busy_end"}, 64'(o_busy), 64'd0);
    @(negedge clk);
    check_eq({tag, "_done_pulse"}, 64'(o_done), 64'd0);
  endtask

  logic [39:0] rv;
  logic        rs;
  logic        re;
  int          dones;

  initial begin
    n_total = 0;
    n_bad   = 0;
    rst     = 1'b1;
    i_start = 1'b0;
    i_value = '0;
    i_sign  = 1'b0;
    i_err   = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_disp", disp_now(), 64'({BLANK, BLANK, BLANK, BLANK, BLANK, BLANK}));
    check_eq("rst_busy", 64'(o_busy), 64'd0);
    check_eq("rst_done", 64'(o_done), 64'd0);
    check_eq("rst_err", 64'(o_err), 64'd0);
    rst = 1'b0;

    run_conv(40'd0, 1'b0, 1'b0, "zero");
    run_conv(40'd999999, 1'b0, 1'b0, "max");
    run_conv(40'd1000000, 1'b0, 1'b0, "over");
    run_conv(40'd1234, 1'b1, 1'b0, "neg1234");
    run_conv(40'd100000, 1'b1, 1'b0, "negover");
    run_conv(40'd99999, 1'b1, 1'b0, "negmax");
    run_conv(40'd0, 1'b1, 1'b0, "negzero");
    run_conv(40'd5, 1'b0, 1'b1, "errflag");
    run_conv(40'h80_0000_0000, 1'b0, 1'b0, "bit39");
    run_conv(40'h00_0010_0007, 1'b0, 1'b0, "bit20");

    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 5))
        0: rv = 40'($urandom_range(0, 9));
        1: rv = 40'($urandom_range(0, 99999));
        2: rv = 40'($urandom_range(0, 999999));
        3: rv = ($urandom_range(0, 1) != 0) ? 40'($urandom_range(99990, 100010))
                                             : 40'($urandom_range(999990, 1000010));
        4: rv = {8'($urandom), 32'($urandom)};
        default: rv = 40'($urandom_range(0, 2000000));
      endcase
      rs = 1'($urandom);
      re = ($urandom_range(0, 7) == 0);
      run_conv(rv, rs, re, "rand");
    end

    // Starts during a conversion are ignored; captured value wins over later input changes.
    @(negedge clk);
    i_value = 40'd123456;
    i_sign  = 1'b0;
    i_err   = 1'b0;
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    dones = 0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (o_done) dones++;
      i_start = (k == 1 || k == 10 || k == 21);
      i_value = 40'($urandom_range(0, 999999));
      i_sign  = 1'($urandom);
    end
    i_start = 1'b0;
    check_eq("multi_done_cnt", 64'(dones), 64'd1);
    check_eq("multi_disp", disp_now(), model_disp(40'd123456, 1'b0, 1'b0));
    check_eq("multi_busy", 64'(o_busy), 64'd0);

    // Reset in the middle of a conversion.
    @(negedge clk);
    i_value = 40'd654321;
    i_sign  = 1'b0;
    i_err   = 1'b0;
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    repeat (11) @(negedge clk);
    rst = 1'b1;
    #2;
    check_eq("midrst_disp", disp_now(), 64'({BLANK, BLANK, BLANK, BLANK, BLANK, BLANK}));
    check_eq("midrst_busy", 64'(o_busy), 64'd0);
    check_eq("midrst_err", 64'(o_err), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    dones = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (o_done) dones++;
    end
    check_eq("midrst_no_done", 64'(dones), 64'd0);
    check_eq("midrst_idle_busy", 64'(o_busy), 64'd0);
    run_conv(40'd654321, 1'b0, 1'b0, "after_rst");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
